// File: rtl/uart_debug_responder.sv
// uart_debug_responder
// Byte-level debug command responder between a UART rx/tx pair and the CPU
// memory bus. The host sends 'W' <addr x4> <data x4> or 'R' <addr x4>, both
// little-endian. The block performs one 32-bit bus access per command.
// It answers ACK_BYTE for a write, four read-data bytes (LSB first) for a
// read, and NAK_BYTE for an unknown opcode.
// Optional feature: define UART_DEBUG_CHECKSUM_EN to require a trailing XOR
// checksum byte (opcode ^ all payload bytes). A bad checksum is answered
// with NAK_BYTE and no bus access is made.
module uart_debug_responder #(
    parameter logic [24:0] TIMEOUT_CYCLES = 25'd24_000_000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_run,
    output logic [7:0]  tx_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
`ifdef UART_DEBUG_CHECKSUM_EN
        S_CSUM,
`endif
        S_BUS,
        S_RESP
    } state_t;

    state_t      r_state;
    logic        r_is_write;     // latched opcode: 1 = 'W', 0 = 'R'
    logic [1:0]  r_byte_cnt;     // payload byte index within the current word
    logic [24:0] r_timeout;      // inter-byte idle countdown
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_resp_shift;   // response bytes, sent from bit 0 upward
    logic [2:0]  r_resp_left;    // response bytes still to send
    logic        r_mem_req;
    logic        r_mem_we;
    logic        r_tx_run;
    logic [7:0]  r_tx_data;
`ifdef UART_DEBUG_CHECKSUM_EN
    logic [7:0]  r_csum;         // running XOR of opcode and payload
`endif

    logic w_last_byte;
    logic w_timed_out;
    logic w_tx_slot;

    // Decode helpers shared by several states
    always_comb begin
        w_last_byte = (r_byte_cnt == 2'd3);
        w_timed_out = (r_timeout == 25'd0);
        // A pulse is never issued in the cycle right after another one,
        // which guarantees at least two cycles between tx_run pulses.
        w_tx_slot   = tx_ready && !r_tx_run;
    end

    // Command FSM with all outputs registered
    // NOTE: the reset branch is asynchronous, so mem_req and tx_run fall the
    // moment reset rises instead of waiting for the next clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_is_write   <= 1'b0;
            r_byte_cnt   <= 2'd0;
            r_timeout    <= 25'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_resp_shift <= 32'd0;
            r_resp_left  <= 3'd0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_tx_run     <= 1'b0;
            r_tx_data    <= 8'd0;
`ifdef UART_DEBUG_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
        end else begin
            // NOTE: state uses non-blocking assignments only. The default
            // below is overridden later in the same block by the RESP
            // branch, which keeps tx_run a one-cycle pulse.
            r_tx_run <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        r_byte_cnt <= 2'd0;
                        r_timeout  <= TIMEOUT_CYCLES;
`ifdef UART_DEBUG_CHECKSUM_EN
                        r_csum     <= rx_data;
`endif
                        if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                            r_is_write <= (rx_data == OP_WRITE);
                            r_state    <= S_ADDR;
                        end else begin
                            r_resp_shift <= {24'd0, NAK_BYTE};
                            r_resp_left  <= 3'd1;
                            r_state      <= S_RESP;
                        end
                    end
                end

                S_ADDR: begin
                    if (rx_valid) begin
                        // Little-endian: each new byte enters at the top, so
                        // after four bytes the first one is at bits [7:0].
                        r_addr     <= {rx_data, r_addr[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_timeout  <= TIMEOUT_CYCLES;
`ifdef UART_DEBUG_CHECKSUM_EN
                        r_csum     <= r_csum ^ rx_data;
`endif
                        if (w_last_byte) begin
                            if (r_is_write) begin
                                r_state <= S_DATA;
                            end else begin
`ifdef UART_DEBUG_CHECKSUM_EN
                                r_state <= S_CSUM;
`else
                                r_state <= S_BUS;
`endif
                            end
                        end
                    end else if (w_timed_out) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timeout <= r_timeout - 25'd1;
                    end
                end

                S_DATA: begin
                    if (rx_valid) begin
                        r_wdata    <= {rx_data, r_wdata[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_timeout  <= TIMEOUT_CYCLES;
`ifdef UART_DEBUG_CHECKSUM_EN
                        r_csum     <= r_csum ^ rx_data;
`endif
                        if (w_last_byte) begin
`ifdef UART_DEBUG_CHECKSUM_EN
                            r_state <= S_CSUM;
`else
                            r_state <= S_BUS;
`endif
                        end
                    end else if (w_timed_out) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timeout <= r_timeout - 25'd1;
                    end
                end

`ifdef UART_DEBUG_CHECKSUM_EN
                S_CSUM: begin
                    if (rx_valid) begin
                        r_timeout <= TIMEOUT_CYCLES;
                        if (rx_data == r_csum) begin
                            r_state <= S_BUS;
                        end else begin
                            r_resp_shift <= {24'd0, NAK_BYTE};
                            r_resp_left  <= 3'd1;
                            r_state      <= S_RESP;
                        end
                    end else if (w_timed_out) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timeout <= r_timeout - 25'd1;
                    end
                end
`endif

                S_BUS: begin
                    // The first BUS cycle raises the request. The address,
                    // data and direction are already frozen, so they stay
                    // stable for the whole request. There is no timeout:
                    // the bus owns the handshake.
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1;
                        r_mem_we  <= r_is_write;
                    end else if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_is_write) begin
                            r_resp_shift <= {24'd0, ACK_BYTE};
                            r_resp_left  <= 3'd1;
                        end else begin
                            r_resp_shift <= mem_rdata;
                            r_resp_left  <= 3'd4;
                        end
                        r_state <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (w_tx_slot) begin
                        r_tx_run     <= 1'b1;
                        r_tx_data    <= r_resp_shift[7:0];
                        r_resp_shift <= {8'd0, r_resp_shift[31:8]};
                        r_resp_left  <= r_resp_left - 3'd1;
                        if (r_resp_left == 3'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered outputs driven straight from state registers
    always_comb begin
        tx_run    = r_tx_run;
        tx_data   = r_tx_data;
        mem_req   = r_mem_req;
        mem_we    = r_mem_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
    end

endmodule
